bomb_sequencer: RTL and testbench

- Lifecycle controller for one bomb slot. It drives the explosion bitmap renderer's bomb_exist, bomb_exploded and direction inputs, and latches the bomb's top-left position for the square-object placer.
- It sequences the slot through IDLE, ARMED (fuse burning), EXPLODING and COOLDOWN, counting frames from the VGA start-of-frame tick.
- It accepts placement requests from the player controller and chain-detonation hits from the collision block.

---
 rtl/bomb_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_bomb_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bomb_sequencer.sv
// Lifecycle controller for a single bomb slot: place, burn fuse, explode,
// cool down. Frame timing comes from the video start-of-frame tick.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | slot empty, waiting for a placement request
// ARMED     | bomb on the field, fuse burning one frame per tick
// EXPLODING | explosion drawn, direction bitmap toggled every DIR_FRAMES
// COOLDOWN  | explosion gone, slot blocked from new placement for a while
module bomb_sequencer #(
  parameter int FUSE_FRAMES     = 120,
  parameter int EXPLODE_FRAMES  = 30,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int DIR_FRAMES      = 4,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic              place_req,
  input  logic [10:0]       place_x,
  input  logic [10:0]       place_y,
  input  logic              chain_hit,
  input  logic              clear,
  output logic              place_ack,
  output logic              bomb_exist,
  output logic              bomb_exploded,
  output logic              direction,
  output logic              explode_pulse,
  output logic [10:0]       topLeftX,
  output logic [10:0]       topLeftY,
  output logic [CNT_W-1:0]  fuse_left
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    EXPLODING = 2'd2,
    COOLDOWN  = 2'd3
  } state_t;

  // Terminal counts; COOLDOWN_FRAMES==0 never enters COOLDOWN, so its value is moot.
  localparam logic [CNT_W-1:0] FUSE_LAST = CNT_W'(FUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] EXPL_LAST = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0] DIR_LAST  = CNT_W'(DIR_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST =
    CNT_W'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             dir_q, dir_d;
  logic [10:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic             ack_q, ack_d;
  logic             pulse_q, pulse_d;
  logic             exist_q, exist_d;
  logic             exploded_q, exploded_d;
  logic [CNT_W-1:0] fuse_q, fuse_d;

  // Next-state and next-output logic; outputs are derived from the next state
  // so that every output port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    ack_d   = 1'b0;
    pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        fcnt_d = '0;
        dcnt_d = '0;
        dir_d  = 1'b0;
        if (place_req) begin
          state_d = ARMED;
          x_d     = place_x;
          y_d     = place_y;
          ack_d   = 1'b1;
        end
      end

      ARMED: begin
        // Fuse expiry and chain hit in the same cycle collapse into one exit.
        if (chain_hit || (startOfFrame && fcnt_q == FUSE_LAST)) begin
          state_d = EXPLODING;
          fcnt_d  = '0;
          dcnt_d  = '0;
          dir_d   = 1'b0;
          pulse_d = 1'b1;
        end else if (startOfFrame) begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end

      EXPLODING: begin
        if (startOfFrame) begin
          if (fcnt_q == EXPL_LAST) begin
            state_d = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
            fcnt_d  = '0;
            dcnt_d  = '0;
            dir_d   = 1'b0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
            if (dcnt_q == DIR_LAST) begin
              dcnt_d = '0;
              dir_d  = ~dir_q;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
      end

      COOLDOWN: begin
        dir_d = 1'b0;
        if (startOfFrame && fcnt_q == COOL_LAST) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else if (startOfFrame) begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Game restart wins over everything, including a same-cycle placement.
    if (clear) begin
      state_d = IDLE;
      fcnt_d  = '0;
      dcnt_d  = '0;
      dir_d   = 1'b0;
      x_d     = '0;
      y_d     = '0;
      ack_d   = 1'b0;
      pulse_d = 1'b0;
    end

    exist_d    = (state_d == ARMED) || (state_d == EXPLODING);
    exploded_d = (state_d == EXPLODING);
    fuse_d     = (state_d == ARMED) ? (FUSE_LAST - fcnt_d) : '0;
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      dcnt_q     <= '0;
      dir_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      ack_q      <= 1'b0;
      pulse_q    <= 1'b0;
      exist_q    <= 1'b0;
      exploded_q <= 1'b0;
      fuse_q     <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      dcnt_q     <= dcnt_d;
      dir_q      <= dir_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ack_q      <= ack_d;
      pulse_q    <= pulse_d;
      exist_q    <= exist_d;
      exploded_q <= exploded_d;
      fuse_q     <= fuse_d;
    end
  end

  assign place_ack     = ack_q;
  assign bomb_exist    = exist_q;
  assign bomb_exploded = exploded_q;
  assign direction     = dir_q;
  assign explode_pulse = pulse_q;
  assign topLeftX      = x_q;
  assign topLeftY      = y_q;
  assign fuse_left     = fuse_q;

endmodule

// File: tb/tb_bomb_sequencer.sv
// Directed bench for bomb_sequencer with FUSE=4, EXPLODE=2, COOLDOWN=1, DIR=1.
module tb_bomb_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             startOfFrame = 1'b0;
  logic             place_req = 1'b0;
  logic [10:0]      place_x = '0;
  logic [10:0]      place_y = '0;
  logic             chain_hit = 1'b0;
  logic             clear = 1'b0;
  logic             place_ack;
  logic             bomb_exist;
  logic             bomb_exploded;
  logic             direction;
  logic             explode_pulse;
  logic [10:0]      topLeftX;
  logic [10:0]      topLeftY;
  logic [CNT_W-1:0] fuse_left;

  int total = 0;
  int bad   = 0;

  bomb_sequencer #(
    .FUSE_FRAMES(4), .EXPLODE_FRAMES(2), .COOLDOWN_FRAMES(1),
    .DIR_FRAMES(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .place_req(place_req), .place_x(place_x), .place_y(place_y),
    .chain_hit(chain_hit), .clear(clear), .place_ack(place_ack),
    .bomb_exist(bomb_exist), .bomb_exploded(bomb_exploded),
    .direction(direction), .explode_pulse(explode_pulse),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .fuse_left(fuse_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ack"},      32'(place_ack),     32'd0);
    chk({tag, ".exist"},    32'(bomb_exist),    32'd0);
    chk({tag, ".exploded"}, 32'(bomb_exploded), 32'd0);
    chk({tag, ".dir"},      32'(direction),     32'd0);
    chk({tag, ".pulse"},    32'(explode_pulse), 32'd0);
    chk({tag, ".x"},        32'(topLeftX),      32'd0);
    chk({tag, ".y"},        32'(topLeftY),      32'd0);
    chk({tag, ".fuse"},     32'(fuse_left),     32'd0);
  endtask

  // One clock: inputs applied on the falling edge, outputs sampled 1ns after rise.
  task automatic step(input logic sof, input logic req, input logic hit, input logic clr,
                      input logic [10:0] x, input logic [10:0] y);
    @(negedge clk);
    startOfFrame = sof;
    place_req    = req;
    chain_hit    = hit;
    clear        = clr;
    place_x      = x;
    place_y      = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and ten idle frames
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("reset");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    end
    chk_zero("idle10");

    // Placement
    step(1'b0, 1'b1, 1'b0, 1'b0, 11'd64, 11'd96);
    chk("place.ack",   32'(place_ack),     32'd1);
    chk("place.exist", 32'(bomb_exist),    32'd1);
    chk("place.expl",  32'(bomb_exploded), 32'd0);
    chk("place.x",     32'(topLeftX),      32'd64);
    chk("place.y",     32'(topLeftY),      32'd96);
    chk("place.fuse",  32'(fuse_left),     32'd3);

    // Request while ARMED is ignored
    step(1'b0, 1'b1, 1'b0, 1'b0, 11'd5, 11'd6);
    chk("armreq.ack", 32'(place_ack), 32'd0);
    chk("armreq.x",   32'(topLeftX),  32'd64);
    chk("armreq.y",   32'(topLeftY),  32'd96);

    // Fuse countdown
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("tick1.fuse", 32'(fuse_left), 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("tick2.fuse", 32'(fuse_left), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("tick3.fuse", 32'(fuse_left),     32'd0);
    chk("tick3.expl", 32'(bomb_exploded), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("tick4.expl",  32'(bomb_exploded), 32'd1);
    chk("tick4.pulse", 32'(explode_pulse), 32'd1);
    chk("tick4.exist", 32'(bomb_exist),    32'd1);
    chk("tick4.dir",   32'(direction),     32'd0);
    chk("tick4.fuse",  32'(fuse_left),     32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0);
    chk("exphit.pulse", 32'(explode_pulse), 32'd0);
    chk("exphit.expl",  32'(bomb_exploded), 32'd1);

    // Explosion, direction toggle, cooldown
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("exp1.dir",  32'(direction),     32'd1);
    chk("exp1.expl", 32'(bomb_exploded), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("cool.exist", 32'(bomb_exist),    32'd0);
    chk("cool.expl",  32'(bomb_exploded), 32'd0);
    chk("cool.dir",   32'(direction),     32'd0);
    chk("cool.x",     32'(topLeftX),      32'd64);
    step(1'b0, 1'b1, 1'b0, 1'b0, 11'd7, 11'd8);
    chk("coolreq.ack", 32'(place_ack), 32'd0);
    chk("coolreq.x",   32'(topLeftX),  32'd64);
    step(1'b1, 1'b1, 1'b0, 1'b0, 11'd7, 11'd8);
    chk("toidle.ack",   32'(place_ack),  32'd0);
    chk("toidle.exist", 32'(bomb_exist), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 11'd200, 11'd300);
    chk("held.ack",   32'(place_ack),  32'd1);
    chk("held.exist", 32'(bomb_exist), 32'd1);
    chk("held.x",     32'(topLeftX),   32'd200);
    chk("held.y",     32'(topLeftY),   32'd300);
    chk("held.fuse",  32'(fuse_left),  32'd3);

    // Chain hit together with a tick at fuse_left=2
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("chain.pre", 32'(fuse_left), 32'd2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0);
    chk("chain.expl",  32'(bomb_exploded), 32'd1);
    chk("chain.pulse", 32'(explode_pulse), 32'd1);
    chk("chain.fuse",  32'(fuse_left),     32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0);
    chk("chain2.pulse", 32'(explode_pulse), 32'd0);
    chk("chain2.expl",  32'(bomb_exploded), 32'd1);

    // Clear during EXPLODING
    step(1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0);
    chk_zero("clear");

    // Clear overrides a same-cycle placement
    step(1'b0, 1'b1, 1'b0, 1'b1, 11'd10, 11'd11);
    chk_zero("clrreq");

    // Async reset mid-ARMED
    step(1'b0, 1'b1, 1'b0, 1'b0, 11'd33, 11'd44);
    chk("rst.pre", 32'(bomb_exist), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("asyncrst");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk_zero("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
